// File: rtl/pulse_stretcher.sv
// Stretches one-cycle request pulses into fixed-length high periods, each followed by a low gap.
// Requests that arrive while busy are queued. Define PULSE_STRETCH_OVF_EN to add the sticky Ovf flag and its Ovf_Clr input.
module pulse_stretcher #(
  parameter int HIGH_TICKS = 8,
  parameter int GAP_TICKS  = 4,
  parameter int PRESCALE   = 1,
  parameter int PEND_W     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Pulse_In,
`ifdef PULSE_STRETCH_OVF_EN
  input  logic              Ovf_Clr,
  output logic              Ovf,
`endif
  output logic              Out_Sig,
  output logic              Busy,
  output logic [PEND_W-1:0] Pend_Cnt
);

  localparam int MAX_TICKS = (HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              tick_s, consume_s, drop_s;
  logic              ovf_q, ovf_d;

  // Next-state, timing counters, request queue and overflow flag.
  always_comb begin
    tick_s    = (pre_q == PRE_LAST);
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    consume_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q != {PEND_W{1'b0}}) begin
          state_d   = ST_HIGH;
          consume_s = 1'b1;
          pre_d     = {PRE_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tick_s) begin
          pre_d = {PRE_W{1'b0}};
          if (cnt_q == HIGH_LAST) begin
            state_d = ST_GAP;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          pre_d = {PRE_W{1'b0}};
          if (cnt_q == GAP_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (pend_q != {PEND_W{1'b0}}) begin
              state_d   = ST_HIGH;
              consume_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pre_d   = {PRE_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // A full queue drops a new request unless one is consumed on the same edge.
    drop_s = Pulse_In && !consume_s && (pend_q == PEND_MAX);
    case ({Pulse_In, consume_s})
      2'b10:   pend_d = drop_s ? pend_q : pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);

`ifdef PULSE_STRETCH_OVF_EN
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (Ovf_Clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
`else
    ovf_d = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pre_q   <= {PRE_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      pend_q  <= {PEND_W{1'b0}};
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Out_Sig  = out_q;
  assign Busy     = busy_q;
  assign Pend_Cnt = pend_q;
`ifdef PULSE_STRETCH_OVF_EN
  assign Ovf = ovf_q;
`else
  logic unused_s;
  assign unused_s = ovf_q ^ drop_s;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default timing plus a PRESCALE=3 instance.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in, pulse3;
  logic       out_sig, busy, out3, busy3;
  logic [2:0] pend, pend3;
`ifdef PULSE_STRETCH_OVF_EN
  logic       ovf_clr, ovf, ovf3;
  logic       ovf_clr3 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int out_hist [0:127];
  int busy_hist[0:127];
  int pend_hist[0:127];
  int ovf_hist [0:127];
  int n_highs, n_high_cycles, min_gap;

  always #5 clk = ~clk;

  pulse_stretcher u_dut (
    .CLK(clk), .RST(rst), .Pulse_In(pulse_in),
`ifdef PULSE_STRETCH_OVF_EN
    .Ovf_Clr(ovf_clr), .Ovf(ovf),
`endif
    .Out_Sig(out_sig), .Busy(busy), .Pend_Cnt(pend)
  );

  pulse_stretcher #(.PRESCALE(3)) u_dut3 (
    .CLK(clk), .RST(rst), .Pulse_In(pulse3),
`ifdef PULSE_STRETCH_OVF_EN
    .Ovf_Clr(ovf_clr3), .Ovf(ovf3),
`endif
    .Out_Sig(out3), .Busy(busy3), .Pend_Cnt(pend3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive n edges (bit k of pulses is Pulse_In on edge k) into one instance and record its outputs.
  task automatic run_seq(input int n, input logic [63:0] pulses, input int sel);
    int prev = 0;
    int low_run = 0;
    n_highs = 0;
    n_high_cycles = 0;
    min_gap = 999;
    for (int k = 0; k < n; k++) begin
      pulse_in = (sel == 0 && k < 64) ? pulses[k] : 1'b0;
      pulse3   = (sel == 1 && k < 64) ? pulses[k] : 1'b0;
      @(posedge clk);
      #1;
      pulse_in = 1'b0;
      pulse3   = 1'b0;
      out_hist[k]  = (sel == 0) ? int'(out_sig) : int'(out3);
      busy_hist[k] = (sel == 0) ? int'(busy) : int'(busy3);
      pend_hist[k] = (sel == 0) ? int'(pend) : int'(pend3);
`ifdef PULSE_STRETCH_OVF_EN
      ovf_hist[k] = int'(ovf);
`else
      ovf_hist[k] = 0;
`endif
      if (out_hist[k] == 1) begin
        n_high_cycles++;
        if (prev == 0) begin
          n_highs++;
          if (n_highs > 1 && low_run < min_gap) min_gap = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev = out_hist[k];
    end
  endtask

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    pulse3 = 1'b0;
`ifdef PULSE_STRETCH_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(out_sig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pend", int'(pend), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pulse
    run_seq(20, 64'h1, 0);
    check("t1_pend_e0", pend_hist[0], 1);
    check("t1_out_e0", out_hist[0], 0);
    check("t1_pend_e1", pend_hist[1], 0);
    check("t1_out_e1", out_hist[1], 1);
    check("t1_out_e8", out_hist[8], 1);
    check("t1_out_e9", out_hist[9], 0);
    check("t1_busy_e12", busy_hist[12], 1);
    check("t1_busy_e13", busy_hist[13], 0);
    check("t1_highs", n_highs, 1);
    check("t1_high_cycles", n_high_cycles, 8);

    // Three back-to-back pulses
    run_seq(45, 64'h7, 0);
    check("t2_pend_e0", pend_hist[0], 1);
    check("t2_pend_e1", pend_hist[1], 1);
    check("t2_pend_e2", pend_hist[2], 2);
    check("t2_out_e12", out_hist[12], 0);
    check("t2_out_e13", out_hist[13], 1);
    check("t2_out_e24", out_hist[24], 0);
    check("t2_out_e25", out_hist[25], 1);
    check("t2_busy_e36", busy_hist[36], 1);
    check("t2_busy_e37", busy_hist[37], 0);
    check("t2_highs", n_highs, 3);
    check("t2_high_cycles", n_high_cycles, 24);
    check("t2_min_gap", min_gap, 4);

    // Saturation: ten pulses, only eight accepted
    run_seq(110, 64'h3FF, 0);
    check("t3_pend_e6", pend_hist[6], 6);
    check("t3_pend_e7", pend_hist[7], 7);
    check("t3_pend_e8", pend_hist[8], 7);
    check("t3_pend_e9", pend_hist[9], 7);
    check("t3_highs", n_highs, 8);
    check("t3_busy_end", busy_hist[109], 0);
`ifdef PULSE_STRETCH_OVF_EN
    check("t3_ovf_e7", ovf_hist[7], 0);
    check("t3_ovf_e8", ovf_hist[8], 1);
    check("t3_ovf_sticky", ovf_hist[109], 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("t3_ovf_clr", int'(ovf), 0);
`endif

    // Async reset mid-HIGH with requests queued
    run_seq(5, 64'hF, 0);
    check("t4_out_e4", out_hist[4], 1);
    check("t4_pend_e4", pend_hist[4], 3);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_out", int'(out_sig), 0);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_pend", int'(pend), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_seq(30, 64'h0, 0);
    check("t4_highs_after", n_highs, 0);
    check("t4_busy_after", busy_hist[29], 0);

    // PRESCALE = 3
    run_seq(60, 64'h1, 1);
    check("t5_out_e1", out_hist[1], 1);
    check("t5_out_e24", out_hist[24], 1);
    check("t5_out_e25", out_hist[25], 0);
    check("t5_busy_e36", busy_hist[36], 1);
    check("t5_busy_e37", busy_hist[37], 0);
    check("t5_high_cycles", n_high_cycles, 24);
    check("t5_highs", n_highs, 1);

    // Pulse on the final GAP edge: increment and consume together
    run_seq(50, 64'h2003, 0);
    check("t6_pend_e12", pend_hist[12], 1);
    check("t6_out_e12", out_hist[12], 0);
    check("t6_pend_e13", pend_hist[13], 1);
    check("t6_out_e13", out_hist[13], 1);
    check("t6_out_e25", out_hist[25], 1);
    check("t6_highs", n_highs, 3);
    check("t6_min_gap", min_gap, 4);
    check("t6_busy_end", busy_hist[49], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
